// File: rtl/ace_pkg.sv
// Shared ACE snoop types for the CCU read path: snoop info from the AR decoder,
// CRRESP bit positions and the aggregated snoop response.
package ace_pkg;

  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t SnpReadOnce   = 4'b0000;
  localparam acsnoop_t SnpReadShared = 4'b0001;
  localparam acsnoop_t SnpReadClean  = 4'b0010;
  localparam acsnoop_t SnpReadUnique = 4'b0111;

  typedef struct packed {
    acsnoop_t snoop_trs;
    logic     accepts_dirty;
    logic     accepts_shared;
  } snoop_info_t;

  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  typedef logic [4:0] crresp_t;

  typedef struct packed {
    logic data_available;
    logic pass_dirty;
    logic is_shared;
    logic was_unique;
    logic error;
    logic writeback_needed;
  } snoop_resp_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBcast = 2'd1,
    StResp  = 2'd2
  } bcast_state_e;

  // A shared line offered to an initiator that cannot take it is reported as an error.
  function automatic snoop_resp_t build_resp(crresp_t acc, snoop_info_t info);
    snoop_resp_t r;
    r.data_available   = acc[CrDataTransfer];
    r.pass_dirty       = acc[CrPassDirty];
    r.is_shared        = acc[CrIsShared] & info.accepts_shared;
    r.was_unique       = acc[CrWasUnique];
    r.error            = acc[CrError] | (acc[CrIsShared] & ~info.accepts_shared);
    r.writeback_needed = acc[CrPassDirty] & ~info.accepts_dirty;
    return r;
  endfunction

endpackage

// File: rtl/ace_crresp_aggregator.sv
// Folds this cycle's accepted CR responses into the running OR accumulator
// and records which ports announced a data transfer.
module ace_crresp_aggregator
  import ace_pkg::*;
#(
  parameter int unsigned NoPorts = 4
) (
  input  logic [NoPorts-1:0]      cr_hs_i,
  input  logic [NoPorts-1:0][4:0] cr_resp_i,
  input  crresp_t                 acc_i,
  input  logic [NoPorts-1:0]      mask_i,
  output crresp_t                 acc_o,
  output logic [NoPorts-1:0]      mask_o
);

  always_comb begin
    acc_o  = acc_i;
    mask_o = mask_i;
    for (int i = 0; i < NoPorts; i++) begin
      if (cr_hs_i[i]) begin
        acc_o     = acc_o | cr_resp_i[i];
        mask_o[i] = cr_resp_i[i][CrDataTransfer];
      end
    end
  end

endmodule

// File: rtl/ace_snoop_broadcaster.sv
// Broadcasts one AC snoop to every master but the initiator, collects all CR
// responses and returns a single aggregated response plus data mask.
module ace_snoop_broadcaster
  import ace_pkg::*;
#(
  parameter int unsigned NoPorts   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter type         ac_chan_t = logic [AddrWidth+6:0],
  localparam int unsigned IdxW     = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [2:0]              req_prot_i,
  input  logic [IdxW-1:0]         req_initiator_i,
  input  snoop_info_t             req_info_i,
  output logic [NoPorts-1:0]      ac_valid_o,
  input  logic [NoPorts-1:0]      ac_ready_i,
  output ac_chan_t                ac_o,
  input  logic [NoPorts-1:0]      cr_valid_i,
  output logic [NoPorts-1:0]      cr_ready_o,
  input  logic [NoPorts-1:0][4:0] cr_resp_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output snoop_resp_t             resp_o,
  output logic [NoPorts-1:0]      data_mask_o
);

  bcast_state_e           state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [2:0]             prot_q, prot_d;
  snoop_info_t            info_q, info_d;
  logic [NoPorts-1:0]     target_q, target_d;
  logic [NoPorts-1:0]     sent_q, sent_d;
  logic [NoPorts-1:0]     got_q, got_d;
  crresp_t                acc_q, acc_d;
  logic [NoPorts-1:0]     mask_q, mask_d;

  logic [NoPorts-1:0]     tgt_new;
  logic [NoPorts-1:0]     ac_hs, cr_hs;
  crresp_t                agg_acc;
  logic [NoPorts-1:0]     agg_mask;

  always_comb begin
    tgt_new = '0;
    for (int i = 0; i < NoPorts; i++) begin
      tgt_new[i] = (IdxW'(i) != req_initiator_i);
    end
  end

  assign ac_hs = ac_valid_o & ac_ready_i;
  assign cr_hs = cr_ready_o & cr_valid_i;

  ace_crresp_aggregator #(
    .NoPorts (NoPorts)
  ) u_agg (
    .cr_hs_i   (cr_hs),
    .cr_resp_i (cr_resp_i),
    .acc_i     (acc_q),
    .mask_i    (mask_q),
    .acc_o     (agg_acc),
    .mask_o    (agg_mask)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      prot_q   <= '0;
      info_q   <= '0;
      target_q <= '0;
      sent_q   <= '0;
      got_q    <= '0;
      acc_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      prot_q   <= prot_d;
      info_q   <= info_d;
      target_q <= target_d;
      sent_q   <= sent_d;
      got_q    <= got_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
    end
  end

  // A single-port system has nobody to snoop and answers with an empty response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = (tgt_new == '0) ? StResp : StBcast;
      StBcast: if ((got_q | cr_hs) == target_q) state_d = StResp;
      StResp:  if (resp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    prot_d   = prot_q;
    info_d   = info_q;
    target_d = target_q;
    sent_d   = sent_q;
    got_d    = got_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    if (state_q == StIdle && req_valid_i) begin
      addr_d   = req_addr_i;
      prot_d   = req_prot_i;
      info_d   = req_info_i;
      target_d = tgt_new;
      sent_d   = '0;
      got_d    = '0;
      acc_d    = '0;
      mask_d   = '0;
    end else if (state_q == StBcast) begin
      sent_d = sent_q | ac_hs;
      got_d  = got_q | cr_hs;
      acc_d  = agg_acc;
      mask_d = agg_mask;
    end
  end

  // CR ready uses the registered sent bit, so a port's CR lands at least one cycle after its AC.
  always_comb begin
    req_ready_o  = 1'b0;
    ac_valid_o   = '0;
    cr_ready_o   = '0;
    resp_valid_o = 1'b0;
    resp_o       = '0;
    data_mask_o  = '0;
    unique case (state_q)
      StIdle:  req_ready_o = 1'b1;
      StBcast: begin
        ac_valid_o = target_q & ~sent_q;
        cr_ready_o = sent_q & ~got_q;
      end
      StResp: begin
        resp_valid_o = 1'b1;
        resp_o       = build_resp(acc_q, info_q);
        data_mask_o  = mask_q;
      end
      default: ;
    endcase
  end

  assign ac_o = ac_chan_t'({addr_q, info_q.snoop_trs, prot_q});

endmodule

// File: tb/tb_ace_snoop_broadcaster.sv
// Self-checking bench for ace_snoop_broadcaster: directed vector table, hand
// sequences for stalls and reset, and randomized transactions against a model.
module tb_ace_snoop_broadcaster;
  import ace_pkg::*;

  logic             clk;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [63:0]      req_addr_i;
  logic [2:0]       req_prot_i;
  logic [1:0]       req_initiator_i;
  snoop_info_t      req_info_i;
  logic [3:0]       ac_valid_o;
  logic [3:0]       ac_ready_i;
  logic [70:0]      ac_o;
  logic [3:0]       cr_valid_i;
  logic [3:0]       cr_ready_o;
  logic [3:0][4:0]  cr_resp_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  snoop_resp_t      resp_o;
  logic [3:0]       data_mask_o;

  int n_checks = 0;
  int n_fail   = 0;

  ace_snoop_broadcaster #(
    .NoPorts   (4),
    .AddrWidth (64)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_prot_i      (req_prot_i),
    .req_initiator_i (req_initiator_i),
    .req_info_i      (req_info_i),
    .ac_valid_o      (ac_valid_o),
    .ac_ready_i      (ac_ready_i),
    .ac_o            (ac_o),
    .cr_valid_i      (cr_valid_i),
    .cr_ready_o      (cr_ready_o),
    .cr_resp_i       (cr_resp_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_o          (resp_o),
    .data_mask_o     (data_mask_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: OR of every snooped port's CRRESP, then the
  // initiator's acceptance rules. Returns {resp[5:0], mask[3:0]}.
  function automatic logic [9:0] model(snoop_info_t info, logic [3:0] target, logic [3:0][4:0] cr);
    logic dt, er, pd, is, wu;
    logic [3:0] mask;
    logic [5:0] r;
    dt = 0; er = 0; pd = 0; is = 0; wu = 0; mask = 0;
    for (int i = 0; i < 4; i++) begin
      if (target[i]) begin
        if (cr[i][0]) begin dt = 1; mask[i] = 1; end
        if (cr[i][1]) er = 1;
        if (cr[i][2]) pd = 1;
        if (cr[i][3]) is = 1;
        if (cr[i][4]) wu = 1;
      end
    end
    r = {dt, pd, is && info.accepts_shared, wu, er || (is && !info.accepts_shared), pd && !info.accepts_dirty};
    return {r, mask};
  endfunction

  task automatic idle_inputs();
    req_valid_i     = 0;
    req_addr_i      = '0;
    req_prot_i      = '0;
    req_initiator_i = '0;
    req_info_i      = '0;
    ac_ready_i      = '0;
    cr_valid_i      = '0;
    cr_resp_i       = '0;
    resp_ready_i    = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
  endtask

  // Drives one transaction from IDLE to back in IDLE, acting as all snoopers.
  // acd/crd: per-port cycles of AC-ready / CR-valid delay; rsd: resp_ready delay.
  task automatic run_txn(input logic [1:0] init, input snoop_info_t info, input logic [63:0] addr,
                         input logic [2:0] prot, input logic [3:0][4:0] cr,
                         input logic [3:0][3:0] acd, input logic [3:0][3:0] crd, input int rsd,
                         output logic [3:0] ac_at1, output int resp_cyc,
                         output logic [5:0] got_resp, output logic [3:0] got_mask);
    logic [3:0]  target, ac_done, cr_done, hs_ac, hs_cr;
    int          ac_cnt[4];
    int          cr_cnt[4];
    logic [9:0]  m;
    logic [70:0] exp_ac;
    logic [5:0]  held;
    int          c;
    logic        done;
    target = 4'b1111 & ~(4'b0001 << init);
    m      = model(info, target, cr);
    exp_ac = {addr, info.snoop_trs, prot};
    chk(req_ready_o === 1'b1, "req_ready_idle", req_ready_o, 1);
    req_valid_i = 1; req_addr_i = addr; req_prot_i = prot;
    req_initiator_i = init; req_info_i = info;
    @(posedge clk); #1;
    req_valid_i = 0; req_addr_i = {$urandom, $urandom}; req_prot_i = 3'($urandom);
    req_info_i = 6'($urandom); req_initiator_i = 2'($urandom);
    ac_done = 0; cr_done = 0; resp_cyc = -1; ac_at1 = 0; got_resp = 0; got_mask = 0;
    for (int i = 0; i < 4; i++) begin ac_cnt[i] = 0; cr_cnt[i] = 0; end
    c = 1; done = 0;
    while (!done && c < 200) begin
      if (c == 1) ac_at1 = ac_valid_o;
      if (resp_valid_o === 1'b1) begin
        resp_cyc = c;
        done = 1;
      end else begin
        chk(ac_valid_o === (target & ~ac_done), "ac_valid", ac_valid_o, target & ~ac_done);
        chk(cr_ready_o === (ac_done & ~cr_done), "cr_ready", cr_ready_o, ac_done & ~cr_done);
        chk(req_ready_o === 1'b0, "req_ready_busy", req_ready_o, 0);
        if (ac_valid_o != 0) chk(ac_o === exp_ac, "ac_payload", ac_o, exp_ac);
        for (int i = 0; i < 4; i++) begin
          ac_ready_i[i] = 0;
          if (ac_valid_o[i]) begin
            if (ac_cnt[i] >= int'(acd[i])) ac_ready_i[i] = 1;
            ac_cnt[i]++;
          end
          cr_valid_i[i] = 0;
          if (ac_done[i] && !cr_done[i]) begin
            if (cr_cnt[i] >= int'(crd[i])) cr_valid_i[i] = 1;
            cr_cnt[i]++;
          end
          cr_resp_i[i] = cr_valid_i[i] ? cr[i] : 5'($urandom);
        end
        hs_ac = ac_valid_o & ac_ready_i;
        hs_cr = cr_valid_i & cr_ready_o;
        @(posedge clk); #1;
        ac_done = ac_done | hs_ac;
        cr_done = cr_done | hs_cr;
        c++;
      end
    end
    ac_ready_i = 0; cr_valid_i = 0;
    if (!done) begin
      chk(1'b0, "resp_timeout", c, 200);
      do_reset();
    end else begin
      got_resp = resp_o;
      got_mask = data_mask_o;
      chk(cr_done === target, "all_cr_before_resp", cr_done, target);
      chk(resp_o === m[9:4], "resp_model", resp_o, m[9:4]);
      chk(data_mask_o === m[3:0], "mask_model", data_mask_o, m[3:0]);
      chk({ac_valid_o, cr_ready_o} === 8'h00, "quiet_in_resp", {ac_valid_o, cr_ready_o}, 0);
      held = resp_o;
      for (int k = 0; k <= rsd; k++) begin
        resp_ready_i = (k == rsd);
        chk(resp_valid_o === 1'b1, "resp_hold", resp_valid_o, 1);
        chk(resp_o === held, "resp_stable", resp_o, held);
        chk(req_ready_o === 1'b0, "req_ready_in_resp", req_ready_o, 0);
        @(posedge clk); #1;
      end
      resp_ready_i = 0;
      chk(resp_valid_o === 1'b0, "resp_drop", resp_valid_o, 0);
      chk(req_ready_o === 1'b1, "back_to_idle", req_ready_o, 1);
    end
  endtask

  typedef struct {
    logic [1:0]      init;
    acsnoop_t        snp;
    logic            acc_d;
    logic            acc_s;
    logic [3:0][4:0] cr;
    logic [3:0]      exp_ac;
    logic [5:0]      exp_resp;
    logic [3:0]      exp_mask;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0]       ac1, gm;
    logic [5:0]       gr;
    int               rc;
    snoop_info_t      info;
    logic [3:0][3:0]  zero_d, acd, crd;
    logic [3:0][4:0]  cr;
    acsnoop_t         snps[4];

    // {init, snoop, accepts_dirty, accepts_shared, {cr3,cr2,cr1,cr0}, ac@1, {da,pd,is,wu,err,wb}, mask}
    vecs[0] = '{2'd1, SnpReadOnce,   1, 1, {5'b00000, 5'b00000, 5'b00000, 5'b00000}, 4'b1101, 6'b000000, 4'b0000};
    vecs[1] = '{2'd1, SnpReadShared, 1, 1, {5'b00000, 5'b00101, 5'b11111, 5'b01000}, 4'b1101, 6'b111000, 4'b0100};
    vecs[2] = '{2'd2, SnpReadUnique, 1, 0, {5'b00000, 5'b00000, 5'b00000, 5'b01000}, 4'b1011, 6'b000010, 4'b0000};
    vecs[3] = '{2'd0, SnpReadClean,  0, 1, {5'b00100, 5'b00000, 5'b00000, 5'b00000}, 4'b1110, 6'b010001, 4'b0000};
    vecs[4] = '{2'd3, SnpReadOnce,   1, 1, {5'b11111, 5'b00000, 5'b00000, 5'b00000}, 4'b0111, 6'b000000, 4'b0000};
    vecs[5] = '{2'd0, SnpReadShared, 1, 1, {5'b00000, 5'b00010, 5'b10000, 5'b00000}, 4'b1110, 6'b000110, 4'b0000};
    vecs[6] = '{2'd2, SnpReadOnce,   1, 1, {5'b00001, 5'b00001, 5'b00001, 5'b00001}, 4'b1011, 6'b100000, 4'b1011};
    snps[0] = SnpReadOnce; snps[1] = SnpReadShared; snps[2] = SnpReadClean; snps[3] = SnpReadUnique;
    zero_d = '0;

    do_reset();
    chk(req_ready_o === 1'b1, "rst_req_ready", req_ready_o, 1);
    chk({ac_valid_o, cr_ready_o, data_mask_o} === 12'h000, "rst_valids", {ac_valid_o, cr_ready_o, data_mask_o}, 0);
    chk(resp_valid_o === 1'b0 && resp_o === 6'b0, "rst_resp", {resp_valid_o, resp_o}, 0);

    foreach (vecs[v]) begin
      info = '{vecs[v].snp, vecs[v].acc_d, vecs[v].acc_s};
      run_txn(vecs[v].init, info, 64'hDEAD_0000_0000_0040 + 64'(v), 3'(v), vecs[v].cr,
              zero_d, zero_d, 0, ac1, rc, gr, gm);
      chk(ac1 === vecs[v].exp_ac, "vec_ac_at_cycle1", ac1, vecs[v].exp_ac);
      chk(rc == 3, "vec_resp_latency", rc, 3);
      chk(gr === vecs[v].exp_resp, "vec_resp", gr, vecs[v].exp_resp);
      chk(gm === vecs[v].exp_mask, "vec_mask", gm, vecs[v].exp_mask);
    end

    // Port 3 stalls its AC for five cycles.
    acd = '0; acd[3] = 4'd5;
    info = '{SnpReadShared, 1'b1, 1'b1};
    run_txn(2'd1, info, 64'h1234_5678_9ABC_DEF0, 3'b101, vecs[1].cr, acd, zero_d, 0, ac1, rc, gr, gm);
    chk(rc == 8, "stall_resp_latency", rc, 8);
    chk(gr === 6'b111000, "stall_resp", gr, 6'b111000);

    // Response consumer holds off for three cycles.
    run_txn(2'd1, info, 64'hCAFE_F00D_0000_1000, 3'b010, vecs[1].cr, zero_d, zero_d, 3, ac1, rc, gr, gm);
    chk(gr === 6'b111000 && gm === 4'b0100, "resp_stall_payload", {gr, gm}, {6'b111000, 4'b0100});

    // Reset in BCAST with CRs from ports 2 and 3 still outstanding.
    req_valid_i = 1; req_addr_i = 64'hAAAA_5555_0000_0080; req_prot_i = 3'b001;
    req_initiator_i = 2'd1; req_info_i = '{SnpReadShared, 1'b1, 1'b1};
    @(posedge clk); #1;
    req_valid_i = 0;
    chk(ac_valid_o === 4'b1101, "rst_seq_ac", ac_valid_o, 4'b1101);
    ac_ready_i = 4'b1101;
    @(posedge clk); #1;
    ac_ready_i = 0;
    chk(cr_ready_o === 4'b1101, "rst_seq_cr_ready", cr_ready_o, 4'b1101);
    cr_valid_i = 4'b0001; cr_resp_i = {5'b0, 5'b0, 5'b0, 5'b00101};
    @(posedge clk); #1;
    cr_valid_i = 0;
    chk(resp_valid_o === 1'b0, "rst_seq_no_early_resp", resp_valid_o, 0);
    rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
    chk(req_ready_o === 1'b1, "midrst_req_ready", req_ready_o, 1);
    chk({ac_valid_o, cr_ready_o, resp_valid_o} === 9'h000, "midrst_valids", {ac_valid_o, cr_ready_o, resp_valid_o}, 0);
    run_txn(2'd0, info, 64'h0BAD_BEEF_0000_0100, 3'b111, {5'b00000, 5'b00000, 5'b00001, 5'b00000},
            zero_d, zero_d, 0, ac1, rc, gr, gm);
    chk(gr === 6'b100000 && gm === 4'b0010, "midrst_next_txn", {gr, gm}, {6'b100000, 4'b0010});

    // Randomized traffic; run_txn checks every cycle and the result against the model.
    for (int t = 0; t < 40; t++) begin
      info = '{snps[$urandom_range(0, 3)], 1'($urandom), 1'($urandom)};
      for (int i = 0; i < 4; i++) begin
        cr[i]  = 5'($urandom);
        acd[i] = 4'($urandom_range(0, 3));
        crd[i] = 4'($urandom_range(0, 3));
      end
      run_txn(2'($urandom), info, {$urandom, $urandom}, 3'($urandom), cr, acd, crd,
              $urandom_range(0, 2), ac1, rc, gr, gm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
